// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the 48 MHz USB PLL, clocked from the 12 MHz reference.
// Releases the PLL, qualifies lock, then releases the USB core reset and finally the D+ pull-up.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 12000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
    parameter int unsigned PULLUP_DELAY_CYCLES = 600,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       i_clk_12mhz,
    input  logic       i_rstn,
    input  logic       i_pll_locked,
    input  logic       i_restart,
    output logic       o_pll_resetb,
    output logic       o_core_resetn,
    output logic       o_usb_pu,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_count,
    output logic       o_fault,
    output logic       o_lock_lost
);

    localparam int unsigned MaxAB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MaxCD  = (LOCK_STABLE_CYCLES > PULLUP_DELAY_CYCLES) ?
                                     LOCK_STABLE_CYCLES : PULLUP_DELAY_CYCLES;
    localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam int unsigned RetW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RESET_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] PullupLast  = CntW'(PULLUP_DELAY_CYCLES - 1);
    localparam logic [RetW-1:0] RetOne      = RetW'(1);
    localparam logic [RetW-1:0] RetMax      = RetW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StPuDelay  = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [RetW-1:0] r_retries;
    logic [RetW-1:0] w_retries_d;
    logic            r_sync1;
    logic            r_lock_sync;
    logic            r_lock_lost;
    logic            w_lock_lost_d;
    logic            r_pll_resetb;
    logic            r_core_resetn;
    logic            r_usb_pu;
    logic            r_fault;
    logic [1:0]      r_retry_count;
    logic            w_pll_resetb_d;
    logic            w_core_resetn_d;
    logic            w_usb_pu_d;
    logic            w_fault_d;
    logic [1:0]      w_retry_count_d;
    logic [31:0]     w_ret_wide;

    always_ff @(posedge i_clk_12mhz) begin
        if (!i_rstn) begin
            r_state       <= StPllRst;
            r_cnt         <= '0;
            r_retries     <= '0;
            r_sync1       <= 1'b0;
            r_lock_sync   <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_pll_resetb  <= 1'b0;
            r_core_resetn <= 1'b0;
            r_usb_pu      <= 1'b0;
            r_fault       <= 1'b0;
            r_retry_count <= 2'd0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_retries     <= w_retries_d;
            r_sync1       <= i_pll_locked;
            r_lock_sync   <= r_sync1;
            r_lock_lost   <= w_lock_lost_d;
            r_pll_resetb  <= w_pll_resetb_d;
            r_core_resetn <= w_core_resetn_d;
            r_usb_pu      <= w_usb_pu_d;
            r_fault       <= w_fault_d;
            r_retry_count <= w_retry_count_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt + CntOne;
        w_retries_d   = r_retries;
        w_lock_lost_d = r_lock_lost;

        unique case (r_state)
            StPllRst: begin
                if (r_cnt == PllRstLast) w_state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing on the same edge.
                if (r_lock_sync) begin
                    w_state_d = StStable;
                end else if (r_cnt == TimeoutLast) begin
                    if (r_retries == RetMax) begin
                        w_state_d = StFault;
                    end else begin
                        w_retries_d = r_retries + RetOne;
                        w_state_d   = StPllRst;
                    end
                end
            end
            StStable: begin
                if (!r_lock_sync) w_state_d = StWaitLock;
                else if (r_cnt == StableLast) w_state_d = StPuDelay;
            end
            StPuDelay, StRun: begin
                if (!r_lock_sync) begin
                    w_state_d     = StPllRst;
                    w_retries_d   = '0;
                    w_lock_lost_d = 1'b1;
                end else if (r_state == StPuDelay && r_cnt == PullupLast) begin
                    w_state_d = StRun;
                end
            end
            StFault: begin
                w_state_d = StFault;
            end
            default: begin
                w_state_d = StPllRst;
            end
        endcase

        // Counter only runs in timed states and restarts on every transition.
        if (w_state_d != r_state || r_state == StRun || r_state == StFault) w_cnt_d = '0;

        if (i_restart) begin
            w_state_d     = StPllRst;
            w_cnt_d       = '0;
            w_retries_d   = '0;
            w_lock_lost_d = 1'b0;
        end

        w_pll_resetb_d  = 1'b0;
        w_core_resetn_d = 1'b0;
        w_usb_pu_d      = 1'b0;
        w_fault_d       = 1'b0;
        unique case (w_state_d)
            StWaitLock, StStable: w_pll_resetb_d = 1'b1;
            StPuDelay: begin
                w_pll_resetb_d  = 1'b1;
                w_core_resetn_d = 1'b1;
            end
            StRun: begin
                w_pll_resetb_d  = 1'b1;
                w_core_resetn_d = 1'b1;
                w_usb_pu_d      = 1'b1;
            end
            StFault: w_fault_d = 1'b1;
            default: w_pll_resetb_d = 1'b0;
        endcase

        w_ret_wide      = 32'(w_retries_d);
        w_retry_count_d = (w_ret_wide >= 32'd3) ? 2'd3 : w_ret_wide[1:0];
    end

    assign o_pll_resetb  = r_pll_resetb;
    assign o_core_resetn = r_core_resetn;
    assign o_usb_pu      = r_usb_pu;
    assign o_state       = r_state;
    assign o_retry_count = r_retry_count;
    assign o_fault       = r_fault;
    assign o_lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer with shortened timing parameters.
// Edge numbers in comments count from the last edge sampled with rstn low (edge 0).
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       core_resetn;
    logic       usb_pu;
    logic [2:0] state;
    logic [1:0] retry_count;
    logic       fault;
    logic       lock_lost;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .PULLUP_DELAY_CYCLES(6),
        .MAX_RETRIES        (2)
    ) u_dut (
        .i_clk_12mhz  (clk),
        .i_rstn       (rstn),
        .i_pll_locked (pll_locked),
        .i_restart    (restart),
        .o_pll_resetb (pll_resetb),
        .o_core_resetn(core_resetn),
        .o_usb_pu     (usb_pu),
        .o_state      (state),
        .o_retry_count(retry_count),
        .o_fault      (fault),
        .o_lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstn       = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        step(3);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_pll_resetb", 32'(pll_resetb), 0);
        check_eq("rst_core_resetn", 32'(core_resetn), 0);
        check_eq("rst_usb_pu", 32'(usb_pu), 0);
        check_eq("rst_fault", 32'(fault), 0);
        check_eq("rst_lock_lost", 32'(lock_lost), 0);
        check_eq("rst_retry", 32'(retry_count), 0);

        // Nominal start
        rstn = 1'b1;
        step(3);                                       // edge 3
        check_eq("nom_pll_resetb_e3", 32'(pll_resetb), 0);
        step(1);                                       // edge 4
        check_eq("nom_pll_resetb_e4", 32'(pll_resetb), 1);
        check_eq("nom_state_e4", 32'(state), 1);
        step(1);                                       // edge 5
        pll_locked = 1'b1;
        step(2);                                       // edge 7
        check_eq("nom_state_e7", 32'(state), 1);
        step(1);                                       // edge 8
        check_eq("nom_state_e8", 32'(state), 2);
        step(7);                                       // edge 15
        check_eq("nom_core_e15", 32'(core_resetn), 0);
        step(1);                                       // edge 16
        check_eq("nom_core_e16", 32'(core_resetn), 1);
        check_eq("nom_state_e16", 32'(state), 3);
        check_eq("nom_pu_e16", 32'(usb_pu), 0);
        step(5);                                       // edge 21
        check_eq("nom_pu_e21", 32'(usb_pu), 0);
        step(1);                                       // edge 22
        check_eq("nom_pu_e22", 32'(usb_pu), 1);
        check_eq("nom_state_e22", 32'(state), 4);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        step(2);                                       // edge 24
        check_eq("loss_core_e24", 32'(core_resetn), 1);
        step(1);                                       // edge 25
        check_eq("loss_core_e25", 32'(core_resetn), 0);
        check_eq("loss_pu_e25", 32'(usb_pu), 0);
        check_eq("loss_lost_e25", 32'(lock_lost), 1);
        check_eq("loss_state_e25", 32'(state), 0);
        check_eq("loss_retry_e25", 32'(retry_count), 0);
        pll_locked = 1'b1;
        step(18);                                      // edge 43
        check_eq("relock_state_e43", 32'(state), 3);
        step(1);                                       // edge 44
        check_eq("relock_state_e44", 32'(state), 4);
        check_eq("relock_pu_e44", 32'(usb_pu), 1);
        check_eq("relock_lost_e44", 32'(lock_lost), 1);

        // Restart in RUN
        restart    = 1'b1;
        pll_locked = 1'b0;
        step(1);                                       // edge 45
        restart = 1'b0;
        check_eq("rs_run_state", 32'(state), 0);
        check_eq("rs_run_lost", 32'(lock_lost), 0);
        check_eq("rs_run_core", 32'(core_resetn), 0);
        check_eq("rs_run_pu", 32'(usb_pu), 0);
        check_eq("rs_run_pll_resetb", 32'(pll_resetb), 0);

        // Timeouts into FAULT
        step(4);                                       // edge 49
        check_eq("to_state_e49", 32'(state), 1);
        step(19);                                      // edge 68
        check_eq("to_state_e68", 32'(state), 1);
        check_eq("to_retry_e68", 32'(retry_count), 0);
        step(1);                                       // edge 69
        check_eq("to_state_e69", 32'(state), 0);
        check_eq("to_retry_e69", 32'(retry_count), 1);
        check_eq("to_pll_resetb_e69", 32'(pll_resetb), 0);
        step(24);                                      // edge 93
        check_eq("to_state_e93", 32'(state), 0);
        check_eq("to_retry_e93", 32'(retry_count), 2);
        step(23);                                      // edge 116
        check_eq("to_state_e116", 32'(state), 1);
        step(1);                                       // edge 117
        check_eq("flt_state", 32'(state), 5);
        check_eq("flt_fault", 32'(fault), 1);
        check_eq("flt_pll_resetb", 32'(pll_resetb), 0);
        check_eq("flt_retry", 32'(retry_count), 2);
        step(100);
        check_eq("flt_hold_state", 32'(state), 5);
        check_eq("flt_hold_fault", 32'(fault), 1);

        // Restart in FAULT (edge R)
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_eq("rs_flt_state", 32'(state), 0);
        check_eq("rs_flt_fault", 32'(fault), 0);
        check_eq("rs_flt_retry", 32'(retry_count), 0);
        check_eq("rs_flt_pll_resetb", 32'(pll_resetb), 0);

        // Restart coinciding with the second timeout (edge R+48)
        step(24);                                      // R+24
        check_eq("rs_to_retry_1", 32'(retry_count), 1);
        step(23);                                      // R+47
        check_eq("rs_to_state_pre", 32'(state), 1);
        restart = 1'b1;
        step(1);                                       // R+48
        restart = 1'b0;
        check_eq("rs_to_state", 32'(state), 0);
        check_eq("rs_to_retry", 32'(retry_count), 0);
        step(3);                                       // R+51
        check_eq("rs_to_state_r51", 32'(state), 0);
        step(1);                                       // W = R+52
        check_eq("rs_to_state_w", 32'(state), 1);

        // Unstable lock during STABLE
        pll_locked = 1'b1;
        step(3);                                       // W+3
        check_eq("unst_state_w3", 32'(state), 2);
        step(2);                                       // W+5
        pll_locked = 1'b0;
        step(2);                                       // W+7
        check_eq("unst_state_w7", 32'(state), 2);
        step(1);                                       // W+8
        check_eq("unst_state_w8", 32'(state), 1);
        check_eq("unst_core_w8", 32'(core_resetn), 0);
        step(1);                                       // W+9
        pll_locked = 1'b1;
        step(10);                                      // W+19
        check_eq("unst_core_w19", 32'(core_resetn), 0);
        step(1);                                       // W+20
        check_eq("unst_core_w20", 32'(core_resetn), 1);
        check_eq("unst_state_w20", 32'(state), 3);

        // Synchronous reset mid PU_DELAY
        step(2);
        check_eq("srst_state_pre", 32'(state), 3);
        rstn = 1'b0;
        #2;
        check_eq("srst_core_async", 32'(core_resetn), 1);
        step(1);
        check_eq("srst_state", 32'(state), 0);
        check_eq("srst_core", 32'(core_resetn), 0);
        check_eq("srst_pll_resetb", 32'(pll_resetb), 0);
        restart = 1'b1;
        step(2);
        restart = 1'b0;
        check_eq("srst_restart_state", 32'(state), 0);
        check_eq("srst_restart_fault", 32'(fault), 0);
        rstn = 1'b1;
        step(3);
        check_eq("srst_rel_e3", 32'(pll_resetb), 0);
        step(1);
        check_eq("srst_rel_e4", 32'(pll_resetb), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
